// File: rtl/spram_traffic_gen.sv
// rtl/spram_traffic_gen.sv - write-then-readback RAM traffic generator with data compare and ECC event counters
module spram_traffic_gen #(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 8,
   parameter int RD_LAT     = 1,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] base_addr,
   input  logic [ADDR_WIDTH:0]   num_words,
   input  logic [DATA_WIDTH-1:0] seed,
   output logic                  cs,
   output logic                  we,
   output logic [ADDR_WIDTH-1:0] addr,
   output logic [DATA_WIDTH-1:0] wr_data,
   input  logic [DATA_WIDTH-1:0] rd_data,
   input  logic                  ecccorr,
   input  logic                  eccderr,
   output logic                  busy,
   output logic                  done,
   output logic                  mismatch,
   output logic [CNT_WIDTH-1:0]  err_cnt,
   output logic [CNT_WIDTH-1:0]  corr_cnt,
   output logic [CNT_WIDTH-1:0]  derr_cnt
);

   localparam int IW = ADDR_WIDTH + 1;
   localparam logic [IW-1:0] MAX_WORDS = IW'(1) << ADDR_WIDTH;

   typedef enum logic [2:0] {S_IDLE, S_WRITE, S_READ, S_DRAIN, S_DONE} state_t;

   function automatic logic [DATA_WIDTH-1:0] pat(input logic [DATA_WIDTH-1:0] s,
                                                 input logic [IW-1:0] i);
      logic [DATA_WIDTH-1:0] iv;
      iv = DATA_WIDTH'(i);
      return s ^ iv ^ {DATA_WIDTH{i[0]}};
   endfunction

   state_t                state_q, state_d;
   logic [IW-1:0]         idx_q, idx_d;
   logic [IW-1:0]         num_q, num_d;
   logic [ADDR_WIDTH-1:0] base_q, base_d;
   logic [DATA_WIDTH-1:0] seed_q, seed_d;
   logic                  cs_q, cs_d;
   logic                  we_q, we_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
   logic [DATA_WIDTH-1:0] exp_q, exp_d;
   logic [2:0]            drain_q, drain_d;
   logic [CNT_WIDTH-1:0]  err_q, err_d;
   logic [CNT_WIDTH-1:0]  corr_q, corr_d;
   logic [CNT_WIDTH-1:0]  derr_q, derr_d;
   logic [RD_LAT-1:0]     vld_pipe_q;
   logic [DATA_WIDTH-1:0] exp_pipe_q [RD_LAT];

   logic [IW-1:0]         num_clamped;
   logic                  pipe_vld;

   assign num_clamped = (num_words > MAX_WORDS) ? MAX_WORDS : num_words;
   assign pipe_vld    = vld_pipe_q[RD_LAT-1];
   assign mismatch    = pipe_vld && (rd_data != exp_pipe_q[RD_LAT-1]);

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      num_d     = num_q;
      base_d    = base_q;
      seed_d    = seed_q;
      cs_d      = 1'b0;
      we_d      = 1'b0;
      addr_d    = addr_q;
      wr_data_d = wr_data_q;
      exp_d     = exp_q;
      drain_d   = drain_q;
      err_d     = (mismatch && err_q != '1) ? err_q + CNT_WIDTH'(1) : err_q;
      corr_d    = (pipe_vld && ecccorr && corr_q != '1) ? corr_q + CNT_WIDTH'(1) : corr_q;
      derr_d    = (pipe_vld && eccderr && derr_q != '1) ? derr_q + CNT_WIDTH'(1) : derr_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               num_d   = num_clamped;
               base_d  = base_addr;
               seed_d  = seed;
               err_d   = '0;
               corr_d  = '0;
               derr_d  = '0;
               drain_d = '0;
               if (num_clamped != '0) begin
                  state_d   = S_WRITE;
                  cs_d      = 1'b1;
                  we_d      = 1'b1;
                  addr_d    = base_addr;
                  wr_data_d = pat(seed, '0);
                  idx_d     = IW'(1);
               end else begin
                  state_d = S_DRAIN;
               end
            end
         end
         S_WRITE: begin
            cs_d = 1'b1;
            // idx_q is the index of the next word to issue; the bus already shows idx_q-1
            if (idx_q == num_q) begin
               state_d = S_READ;
               addr_d  = base_q;
               exp_d   = pat(seed_q, '0);
               idx_d   = IW'(1);
            end else begin
               we_d      = 1'b1;
               addr_d    = base_q + ADDR_WIDTH'(idx_q);
               wr_data_d = pat(seed_q, idx_q);
               idx_d     = idx_q + IW'(1);
            end
         end
         S_READ: begin
            if (idx_q == num_q) begin
               state_d = S_DRAIN;
               drain_d = '0;
            end else begin
               cs_d   = 1'b1;
               addr_d = base_q + ADDR_WIDTH'(idx_q);
               exp_d  = pat(seed_q, idx_q);
               idx_d  = idx_q + IW'(1);
            end
         end
         S_DRAIN: begin
            if (drain_q == 3'(RD_LAT)) state_d = S_DONE;
            else                       drain_d = drain_q + 3'd1;
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         idx_q      <= '0;
         num_q      <= '0;
         base_q     <= '0;
         seed_q     <= '0;
         cs_q       <= 1'b0;
         we_q       <= 1'b0;
         addr_q     <= '0;
         wr_data_q  <= '0;
         exp_q      <= '0;
         drain_q    <= '0;
         err_q      <= '0;
         corr_q     <= '0;
         derr_q     <= '0;
         vld_pipe_q <= '0;
         for (int i = 0; i < RD_LAT; i++) exp_pipe_q[i] <= '0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         num_q      <= num_d;
         base_q     <= base_d;
         seed_q     <= seed_d;
         cs_q       <= cs_d;
         we_q       <= we_d;
         addr_q     <= addr_d;
         wr_data_q  <= wr_data_d;
         exp_q      <= exp_d;
         drain_q    <= drain_d;
         err_q      <= err_d;
         corr_q     <= corr_d;
         derr_q     <= derr_d;
         // Each read on the bus enters the expect pipeline; its tail lines up with rd_data
         vld_pipe_q[0] <= cs_q & ~we_q;
         exp_pipe_q[0] <= exp_q;
         for (int i = 1; i < RD_LAT; i++) begin
            vld_pipe_q[i] <= vld_pipe_q[i-1];
            exp_pipe_q[i] <= exp_pipe_q[i-1];
         end
      end
   end

   assign cs       = cs_q;
   assign we       = we_q;
   assign addr     = addr_q;
   assign wr_data  = wr_data_q;
   assign busy     = (state_q == S_WRITE) || (state_q == S_READ) || (state_q == S_DRAIN);
   assign done     = (state_q == S_DONE);
   assign err_cnt  = err_q;
   assign corr_cnt = corr_q;
   assign derr_cnt = derr_q;

endmodule

// File: tb/tb_spram_traffic_gen.sv
// tb/tb_spram_traffic_gen.sv - directed vector bench for spram_traffic_gen with a 1-cycle RAM model
module tb_spram_traffic_gen;

   logic        clk, rst, start;
   logic [7:0]  base_addr;
   logic [8:0]  num_words;
   logic [7:0]  seed;
   logic        cs, we;
   logic [7:0]  addr, wr_data, rd_data;
   logic        ecccorr, eccderr;
   logic        busy, done, mismatch;
   logic [15:0] err_cnt, corr_cnt, derr_cnt;

   logic [7:0]  mem [256];
   logic [7:0]  ram_rd;
   logic        flip, corr_f, derr_f;

   int n_cmp = 0;
   int n_fail = 0;

   spram_traffic_gen #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .RD_LAT(1), .CNT_WIDTH(16)) dut (
      .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .num_words(num_words),
      .seed(seed), .cs(cs), .we(we), .addr(addr), .wr_data(wr_data), .rd_data(rd_data),
      .ecccorr(ecccorr), .eccderr(eccderr), .busy(busy), .done(done), .mismatch(mismatch),
      .err_cnt(err_cnt), .corr_cnt(corr_cnt), .derr_cnt(derr_cnt)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (cs && we)  mem[addr] <= wr_data;
      if (cs && !we) ram_rd <= mem[addr];
   end

   assign rd_data = ram_rd ^ {7'b0, flip};
   assign ecccorr = corr_f;
   assign eccderr = derr_f;

   typedef struct {
      logic [7:0] base;
      logic [8:0] num;
      logic [7:0] seed;
      int         flip_cyc;
      int         ecc_cyc;
      int         derr_cyc;
      bit         start_at_done;
      int         exp_len;
      int         exp_n;
      logic [7:0] exp_first;
      logic [7:0] exp_last_wd;
      logic [7:0] exp_last_addr;
      int         exp_err;
      int         exp_corr;
      int         exp_derr;
      int         exp_mm_cyc;
   } vec_t;

   vec_t vecs [7];

   function automatic logic [7:0] pat(input logic [7:0] s, input int i);
      logic [7:0] iv;
      iv = 8'(i);
      return s ^ iv ^ {8{iv[0]}};
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic bit outs_zero();
      return !cs && !we && addr == 8'h0 && wr_data == 8'h0 && !busy && !done && !mismatch &&
             err_cnt == 16'h0 && corr_cnt == 16'h0 && derr_cnt == 16'h0;
   endfunction

   task automatic run(input vec_t v, input int id);
      int len = 0, wr = 0, rd = 0, mm = 0, mm_cyc = 0, seq_bad = 0, busy_bad = 0;
      logic [7:0] first = 8'h0, last_wd = 8'h0, last_addr = 8'h0, ea;
      @(posedge clk); #1;
      base_addr = v.base; num_words = v.num; seed = v.seed; start = 1'b1;
      for (int k = 1; k <= v.exp_len + 20; k++) begin
         @(posedge clk); #1;
         start  = v.start_at_done && (k == v.exp_len);
         flip   = (k == v.flip_cyc);
         corr_f = (k == v.ecc_cyc);
         derr_f = (k == v.ecc_cyc) || (k == v.derr_cyc);
         @(negedge clk);
         if (cs && we) begin
            ea = v.base + 8'(wr);
            if (wr == 0) first = wr_data;
            if (addr !== ea || wr_data !== pat(v.seed, wr)) seq_bad++;
            last_wd = wr_data; last_addr = addr; wr++;
         end
         if (cs && !we) begin
            ea = v.base + 8'(rd);
            if (addr !== ea) seq_bad++;
            rd++;
         end
         if (mismatch) begin
            mm++;
            if (mm_cyc == 0) mm_cyc = k;
         end
         if (done) begin
            if (busy) busy_bad++;
            len = k;
            break;
         end
         if (!busy) busy_bad++;
      end
      @(posedge clk); #1;
      start = 1'b0; flip = 1'b0; corr_f = 1'b0; derr_f = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         if (busy || cs || done) busy_bad++;
         @(posedge clk); #1;
      end
      chk($sformatf("v%0d run length", id), len, v.exp_len);
      chk($sformatf("v%0d writes", id), wr, v.exp_n);
      chk($sformatf("v%0d reads", id), rd, v.exp_n);
      chk($sformatf("v%0d first wdata", id), first, v.exp_first);
      chk($sformatf("v%0d last wdata", id), last_wd, v.exp_last_wd);
      chk($sformatf("v%0d last waddr", id), last_addr, v.exp_last_addr);
      chk($sformatf("v%0d bus sequence errors", id), seq_bad, 0);
      chk($sformatf("v%0d busy/idle errors", id), busy_bad, 0);
      chk($sformatf("v%0d err_cnt", id), err_cnt, v.exp_err);
      chk($sformatf("v%0d corr_cnt", id), corr_cnt, v.exp_corr);
      chk($sformatf("v%0d derr_cnt", id), derr_cnt, v.exp_derr);
      chk($sformatf("v%0d mismatch pulses", id), mm, v.exp_err);
      chk($sformatf("v%0d mismatch cycle", id), mm_cyc, v.exp_mm_cyc);
   endtask

   initial begin
      int bad;
      int dn;
      clk = 1'b0; rst = 1'b1; start = 1'b0; base_addr = '0; num_words = '0; seed = '0;
      flip = 1'b0; corr_f = 1'b0; derr_f = 1'b0;

      //         base   num     seed   flip ecc derr sad len  n    first  lastwd lastad err corr derr mmcyc
      vecs[0] = '{8'h10, 9'd4,   8'hA5, 0,   0,  0,   0,  11,  4,   8'hA5, 8'h59, 8'h13, 0,  0,   0,   0};
      vecs[1] = '{8'hFE, 9'd4,   8'h3C, 0,   0,  0,   0,  11,  4,   8'h3C, 8'hC0, 8'h01, 0,  0,   0,   0};
      vecs[2] = '{8'h40, 9'd4,   8'h11, 7,   8,  10,  0,  11,  4,   8'h11, 8'hED, 8'h43, 1,  1,   1,   7};
      vecs[3] = '{8'h80, 9'd0,   8'h00, 0,   0,  0,   0,  3,   0,   8'h00, 8'h00, 8'h00, 0,  0,   0,   0};
      vecs[4] = '{8'h00, 9'd1,   8'h00, 0,   0,  0,   1,  5,   1,   8'h00, 8'h00, 8'h00, 0,  0,   0,   0};
      vecs[5] = '{8'h20, 9'd2,   8'hFF, 0,   0,  4,   0,  7,   2,   8'hFF, 8'h01, 8'h21, 0,  0,   1,   0};
      vecs[6] = '{8'h00, 9'h1FF, 8'h5A, 0,   0,  0,   0,  515, 256, 8'h5A, 8'h5A, 8'hFF, 0,  0,   0,   0};

      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("reset cs", cs, 0);
      chk("reset busy", busy, 0);
      chk("reset done", done, 0);
      chk("reset err_cnt", err_cnt, 0);
      bad = 0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         if (!outs_zero()) bad++;
      end
      chk("idle outputs nonzero cycles", bad, 0);

      for (int v = 0; v < 7; v++) run(vecs[v], v);

      // Reset asserted during the READ phase of an 8-word run
      @(posedge clk); #1;
      base_addr = 8'h00; num_words = 9'd8; seed = 8'h77; start = 1'b1;
      for (int k = 1; k <= 11; k++) begin
         @(posedge clk); #1;
         start = 1'b0;
         if (k == 11) rst = 1'b1;
      end
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("mid-run reset outputs zero", outs_zero(), 1);
      dn = 0;
      for (int k = 0; k < 25; k++) begin
         @(negedge clk);
         if (done || busy || cs) dn++;
      end
      chk("aborted run activity after reset", dn, 0);
      run(vecs[0], 7);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
